// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an asynchronous FIFO: binary/Gray read pointer, RAM read
// address and registered empty/almost-empty/occupancy status. Optional macro: FIFO_RD_UNDERFLOW_EN.
module fifo_rd_ctrl #(
  parameter int DEPTH         = 16,
  parameter int AEMPTY_THRESH = 2,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic          r_clk,
  input  logic          rst,
  input  logic          r_en,
  input  logic [AW:0]   rsync_ptr2,
  output logic [AW-1:0] raddr,
  output logic [AW:0]   rptr,
  output logic          r_empty,
  output logic          r_aempty,
  output logic [AW:0]   r_count
`ifdef FIFO_RD_UNDERFLOW_EN
  ,
  output logic          r_underflow
`endif
);

  logic [AW:0] rbin_reg;
  logic [AW:0] rbin_next;
  logic [AW:0] rgray_next;
  logic [AW:0] wbin_s;
  logic [AW:0] count_next;
  logic        rd_ok;

  assign rd_ok      = r_en & ~r_empty;
  assign rbin_next  = rbin_reg + {{AW{1'b0}}, rd_ok};
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;
  assign raddr      = rbin_reg[AW-1:0];

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at and above it.
  assign wbin_s[AW] = rsync_ptr2[AW];
  generate
    for (genvar gi = AW - 1; gi >= 0; gi--) begin : g_g2b
      assign wbin_s[gi] = wbin_s[gi+1] ^ rsync_ptr2[gi];
    end
  endgenerate

  // Status is computed from the post-read pointer so the last read flags empty with no bubble.
  assign count_next = wbin_s - rbin_next;

  always_ff @(posedge r_clk) begin
    if (rst) begin
      rbin_reg <= '0;
      rptr     <= '0;
      r_empty  <= 1'b1;
      r_aempty <= 1'b1;
      r_count  <= '0;
    end else begin
      rbin_reg <= rbin_next;
      rptr     <= rgray_next;
      r_empty  <= (rgray_next == rsync_ptr2);
      r_aempty <= (count_next <= (AW+1)'(AEMPTY_THRESH));
      r_count  <= count_next;
    end
  end

`ifdef FIFO_RD_UNDERFLOW_EN
  // Sticky: any attempted read while empty is latched until reset.
  always_ff @(posedge r_clk) begin
    if (rst) begin
      r_underflow <= 1'b0;
    end else if (r_en && r_empty) begin
      r_underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl (DEPTH=16, AEMPTY_THRESH=2); covers reset, fill,
// drain, wrap, simultaneous read/write and, with FIFO_RD_UNDERFLOW_EN, underflow.
module tb_fifo_rd_ctrl;

  logic       r_clk = 1'b0;
  logic       rst;
  logic       r_en;
  logic [4:0] rsync_ptr2;
  logic [3:0] raddr;
  logic [4:0] rptr;
  logic       r_empty;
  logic       r_aempty;
  logic [4:0] r_count;
`ifdef FIFO_RD_UNDERFLOW_EN
  logic       r_underflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fifo_rd_ctrl #(.DEPTH(16), .AEMPTY_THRESH(2)) dut (
    .r_clk      (r_clk),
    .rst        (rst),
    .r_en       (r_en),
    .rsync_ptr2 (rsync_ptr2),
    .raddr      (raddr),
    .rptr       (rptr),
    .r_empty    (r_empty),
    .r_aempty   (r_aempty),
`ifdef FIFO_RD_UNDERFLOW_EN
    .r_underflow(r_underflow),
`endif
    .r_count    (r_count)
  );

  always #5 r_clk = ~r_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one edge and let outputs settle before sampling.
  task automatic step();
    @(posedge r_clk);
    #1;
  endtask

  function automatic logic [4:0] gray(input int b);
    logic [4:0] v;
    v = b[4:0];
    return (v >> 1) ^ v;
  endfunction

  logic [4:0] prev_ptr;

  initial begin
    rst = 1'b1; r_en = 1'b1; rsync_ptr2 = 5'b00000;
    step(); step();
    rst = 1'b0;
    check("rst_rptr", 32'(rptr), 32'd0);
    check("rst_raddr", 32'(raddr), 32'd0);
    check("rst_empty", 32'(r_empty), 32'd1);
    check("rst_aempty", 32'(r_aempty), 32'd1);
    check("rst_count", 32'(r_count), 32'd0);
`ifdef FIFO_RD_UNDERFLOW_EN
    check("rst_uflow", 32'(r_underflow), 32'd0);
`endif
    step();
    check("rst_hold_raddr", 32'(raddr), 32'd0);
    check("rst_hold_rptr", 32'(rptr), 32'd0);
    r_en = 1'b0;

    // Fill visibility
    rsync_ptr2 = 5'b00001; step();
    check("fill1_empty", 32'(r_empty), 32'd0);
    check("fill1_count", 32'(r_count), 32'd1);
    check("fill1_aempty", 32'(r_aempty), 32'd1);
    rsync_ptr2 = 5'b00011; step();
    check("fill2_empty", 32'(r_empty), 32'd0);
    check("fill2_count", 32'(r_count), 32'd2);
    check("fill2_aempty", 32'(r_aempty), 32'd1);

    // Drain
    r_en = 1'b1;
    check("drain0_raddr", 32'(raddr), 32'd0);
    step();
    check("drain1_raddr", 32'(raddr), 32'd1);
    check("drain1_rptr", 32'(rptr), 32'b00001);
    check("drain1_count", 32'(r_count), 32'd1);
    check("drain1_empty", 32'(r_empty), 32'd0);
    step();
    check("drain2_raddr", 32'(raddr), 32'd2);
    check("drain2_rptr", 32'(rptr), 32'b00011);
    check("drain2_empty", 32'(r_empty), 32'd1);
    check("drain2_count", 32'(r_count), 32'd0);
    step();
    check("drain3_raddr", 32'(raddr), 32'd2);
    check("drain3_rptr", 32'(rptr), 32'b00011);
    check("drain3_empty", 32'(r_empty), 32'd1);
    r_en = 1'b0;

    // Wrap: full FIFO from rbin=0, drained to empty
    rst = 1'b1; step(); rst = 1'b0;
    rsync_ptr2 = 5'b11000; step();
    check("wrap_full_count", 32'(r_count), 32'd16);
    check("wrap_full_empty", 32'(r_empty), 32'd0);
    check("wrap_full_aempty", 32'(r_aempty), 32'd0);
    r_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      prev_ptr = rptr;
      step();
      check($sformatf("wrap%0d_raddr", i), 32'(raddr), 32'(i % 16));
      check($sformatf("wrap%0d_count", i), 32'(r_count), 32'(16 - i));
      check($sformatf("wrap%0d_rptr", i), 32'(rptr), 32'(gray(i)));
      check($sformatf("wrap%0d_onebit", i), 32'($countones(rptr ^ prev_ptr)), 32'd1);
      check($sformatf("wrap%0d_aempty", i), 32'(r_aempty), 32'((16 - i) <= 2));
      check($sformatf("wrap%0d_empty", i), 32'(r_empty), 32'(i == 16));
    end
    r_en = 1'b0;
    check("wrap_final_rptr", 32'(rptr), 32'b11000);

    // Simultaneous read and write-pointer advance (rbin=16)
    rsync_ptr2 = 5'b11001; step();
    check("sim_pre_count", 32'(r_count), 32'd1);
    check("sim_pre_empty", 32'(r_empty), 32'd0);
    r_en = 1'b1; rsync_ptr2 = 5'b11011; step();
    check("sim_empty", 32'(r_empty), 32'd0);
    check("sim_count", 32'(r_count), 32'd1);
    check("sim_raddr", 32'(raddr), 32'd1);
    check("sim_rptr", 32'(rptr), 32'b11001);

`ifdef FIFO_RD_UNDERFLOW_EN
    check("uf_pre", 32'(r_underflow), 32'd0);
`endif
    step();
    check("uf_last_empty", 32'(r_empty), 32'd1);
    check("uf_last_raddr", 32'(raddr), 32'd2);
    step();
    check("uf_ign_raddr", 32'(raddr), 32'd2);
    check("uf_ign_rptr", 32'(rptr), 32'b11011);
`ifdef FIFO_RD_UNDERFLOW_EN
    check("uf_set", 32'(r_underflow), 32'd1);
`endif
    r_en = 1'b0; rsync_ptr2 = 5'b11010; step();
    check("uf_refill_empty", 32'(r_empty), 32'd0);
    r_en = 1'b1; step();
    r_en = 1'b0;
    check("uf_valid_raddr", 32'(raddr), 32'd3);
    check("uf_valid_empty", 32'(r_empty), 32'd1);
`ifdef FIFO_RD_UNDERFLOW_EN
    check("uf_sticky", 32'(r_underflow), 32'd1);
`endif

    // Reset mid-operation with a non-zero write pointer
    rst = 1'b1; step();
    check("mrst_rptr", 32'(rptr), 32'd0);
    check("mrst_raddr", 32'(raddr), 32'd0);
    check("mrst_empty", 32'(r_empty), 32'd1);
    check("mrst_count", 32'(r_count), 32'd0);
`ifdef FIFO_RD_UNDERFLOW_EN
    check("mrst_uflow", 32'(r_underflow), 32'd0);
`endif
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
